// File: rtl/io_hex_if.sv
// CPU-side write port of the hex display: strobe, data word, mode select and status.
// The CPU drives through master; the display consumes through slave.
interface io_hex_if #(
    parameter int NBITS = 32
);
    logic             io_we;
    logic [NBITS-1:0] io_wdata;
    logic             mode_dec;
    logic             busy;
    logic             ovf;

    modport master (
        output io_we,
        output io_wdata,
        output mode_dec,
        input  busy,
        input  ovf
    );

    modport slave (
        input  io_we,
        input  io_wdata,
        input  mode_dec,
        output busy,
        output ovf
    );
endinterface : io_hex_if

// File: rtl/io_hex_display.sv
// Captures CPU display writes and drives eight active-low seven-segment digits,
// either as raw hex or as decimal via a 1-bit-per-cycle double-dabble converter.
module io_hex_display #(
    parameter bit BLANK_LEADING = 1'b1,
    parameter int NBITS         = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    io_hex_if.slave    bus,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [6:0] HEX6,
    output logic [6:0] HEX7
);

    localparam int         BCD_DIGITS = 10;
    localparam int         BCD_W      = 4 * BCD_DIGITS;
    localparam logic [5:0] CNT_LAST   = 6'(NBITS - 1);
    localparam logic [6:0] SEG_OFF    = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DISP
    } state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Double-dabble correction: any digit >= 5 would overflow past 9 after the shift.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [NBITS-1:0] shreg_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] bcd_adj;
    logic [5:0]       cnt_q;
    logic             cur_dec_q;
    logic             pend_valid_q;
    logic [NBITS-1:0] pend_word_q;
    logic             pend_dec_q;
    logic [6:0]       hex_q [8];
    logic             ovf_q;

    logic             load;
    logic [NBITS-1:0] load_word;
    logic             load_dec;
    logic             pend_set;
    logic             pend_clr;
    logic             shift_en;
    logic             disp_en;

    logic [6:0]       seg_d [8];
    logic             ovf_d;
    logic [2:0]       msd;
    logic [31:0]      hex_word;

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        load_word = bus.io_wdata;
        load_dec  = bus.mode_dec;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        shift_en  = 1'b0;
        disp_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                load = bus.io_we;
            end
            SHIFT: begin
                shift_en = 1'b1;
                pend_set = bus.io_we;
                if (cnt_q == CNT_LAST) state_d = DISP;
            end
            DISP: begin
                disp_en = 1'b1;
                state_d = IDLE;
                if (pend_valid_q) begin
                    // Launch the parked word; a write landing now takes its slot.
                    load      = 1'b1;
                    load_word = pend_word_q;
                    load_dec  = pend_dec_q;
                    pend_clr  = 1'b1;
                    pend_set  = bus.io_we;
                end else begin
                    load = bus.io_we;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) state_d = load_dec ? SHIFT : DISP;
    end

    assign bcd_adj  = bcd_adjust(bcd_q);
    assign hex_word = 32'(shreg_q);

    // Segment images for the word that has just finished; latched only in DISP.
    always_comb begin
        ovf_d = 1'b0;
        msd   = 3'd0;
        for (int i = 0; i < 8; i++) seg_d[i] = SEG_OFF;

        if (cur_dec_q) begin
            ovf_d = |bcd_q[BCD_W-1:32];
            for (int i = 1; i < 8; i++) begin
                if (bcd_q[4*i +: 4] != 4'd0) msd = 3'(i);
            end
            for (int i = 0; i < 8; i++) begin
                if (BLANK_LEADING && !ovf_d && (3'(i) > msd)) seg_d[i] = SEG_OFF;
                else                                          seg_d[i] = seg7(bcd_q[4*i +: 4]);
            end
        end else begin
            for (int i = 0; i < 8; i++) seg_d[i] = seg7(hex_word[4*i +: 4]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            cur_dec_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_word_q  <= '0;
            pend_dec_q   <= 1'b0;
            ovf_q        <= 1'b0;
            for (int i = 0; i < 8; i++) hex_q[i] <= SEG_OFF;
        end else begin
            state_q <= state_d;

            if (load) begin
                shreg_q   <= load_word;
                bcd_q     <= '0;
                cnt_q     <= '0;
                cur_dec_q <= load_dec;
            end else if (shift_en) begin
                bcd_q   <= {bcd_adj[BCD_W-2:0], shreg_q[NBITS-1]};
                shreg_q <= {shreg_q[NBITS-2:0], 1'b0};
                if (cnt_q != 6'h3F) cnt_q <= cnt_q + 6'd1;
            end

            if (pend_set) begin
                pend_valid_q <= 1'b1;
                pend_word_q  <= bus.io_wdata;
                pend_dec_q   <= bus.mode_dec;
            end else if (pend_clr) begin
                pend_valid_q <= 1'b0;
            end

            if (disp_en) begin
                hex_q <= seg_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.ovf  = ovf_q;

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];
    assign HEX6 = hex_q[6];
    assign HEX7 = hex_q[7];

endmodule : io_hex_display

// File: tb/tb_io_hex_display.sv
// Directed bench for io_hex_display: hex and decimal display, blanking, overflow,
// async reset mid-conversion, and the one-deep pending write slot.
module tb_io_hex_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] hex [8];
    int         errors = 0;
    int         checks = 0;
    int         busy_low;
    int         early;
    int         saw200;

    always #5 clk = ~clk;

    io_hex_if #(.NBITS(32)) bus ();

    io_hex_display #(
        .BLANK_LEADING(1'b1),
        .NBITS        (32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .HEX0 (hex[0]),
        .HEX1 (hex[1]),
        .HEX2 (hex[2]),
        .HEX3 (hex[3]),
        .HEX4 (hex[4]),
        .HEX5 (hex[5]),
        .HEX6 (hex[6]),
        .HEX7 (hex[7])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected digits given as {HEX7, ..., HEX0}.
    task automatic check_hex(input string tag, input logic [7:0][6:0] e);
        for (int i = 0; i < 8; i++) chk($sformatf("%s_hex%0d", tag, i), 32'(hex[i]), 32'(e[i]));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write(input logic [31:0] d, input logic dec);
        bus.io_we    = 1'b1;
        bus.io_wdata = d;
        bus.mode_dec = dec;
        tick(1);
        bus.io_we    = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < max) begin
            tick(1);
            n++;
        end
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.io_we    = 1'b0;
        bus.io_wdata = '0;
        bus.mode_dec = 1'b0;
        rst_n        = 1'b0;
        tick(2);
        check_hex("rst", {8{7'h7F}});
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Decimal 12345: busy through E33, display only after E33.
        write(32'd12345, 1'b1);
        busy_low = 0;
        early    = 0;
        for (int i = 0; i < 32; i++) begin
            if (bus.busy !== 1'b1) busy_low++;
            if (hex[0] !== 7'h7F) early++;
            tick(1);
        end
        chk("dec_busy_low_cycles", 32'(busy_low), 32'd0);
        chk("dec_no_partial", 32'(early), 32'd0);
        chk("dec_busy_e32", 32'(bus.busy), 32'd1);
        chk("dec_hold_e32", 32'(hex[0]), 32'h7F);
        tick(1);
        check_hex("dec12345", {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
        chk("dec12345_busy", 32'(bus.busy), 32'd0);
        chk("dec12345_ovf", 32'(bus.ovf), 32'd0);

        // Hex DEADBEEF: one cycle of latency, no blanking.
        write(32'hDEAD_BEEF, 1'b0);
        chk("hex_busy_e0", 32'(bus.busy), 32'd1);
        tick(1);
        check_hex("hexDEADBEEF", {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E});
        chk("hex_busy", 32'(bus.busy), 32'd0);
        chk("hex_ovf", 32'(bus.ovf), 32'd0);

        // Decimal 4294967295: overflow, lower eight digits 94967295.
        write(32'hFFFF_FFFF, 1'b1);
        tick(33);
        check_hex("dec_max", {7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12});
        chk("dec_max_ovf", 32'(bus.ovf), 32'd1);
        chk("dec_max_busy", 32'(bus.busy), 32'd0);

        // Async reset in the middle of a conversion.
        write(32'd0, 1'b1);
        tick(10);
        #2 rst_n = 1'b0;
        #1;
        check_hex("async_rst", {8{7'h7F}});
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        chk("async_rst_ovf", 32'(bus.ovf), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("post_rst_idle", 32'(bus.busy), 32'd0);
        check_hex("post_rst_hold", {8{7'h7F}});

        // Decimal 0: only HEX0 lit.
        write(32'd0, 1'b1);
        tick(33);
        check_hex("dec_zero", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        chk("dec_zero_ovf", 32'(bus.ovf), 32'd0);

        // Back-to-back: 100 @E0, 200 @E5, 300 @E10; 200 is overwritten in the slot.
        busy_low = 0;
        saw200   = 0;
        for (int e = 0; e <= 67; e++) begin
            bus.io_we    = (e == 0) || (e == 5) || (e == 10);
            bus.io_wdata = (e == 0) ? 32'd100 : (e == 5) ? 32'd200 : 32'd300;
            bus.mode_dec = 1'b1;
            tick(1);
            bus.io_we = 1'b0;
            if (e <= 65 && bus.busy !== 1'b1) busy_low++;
            if (hex[2] === 7'h24) saw200++;
            if (e == 33) check_hex("b2b_100", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40});
        end
        chk("b2b_busy_low_cycles", 32'(busy_low), 32'd0);
        chk("b2b_200_skipped", 32'(saw200), 32'd0);
        check_hex("b2b_300", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40, 7'h40});
        chk("b2b_busy_end", 32'(bus.busy), 32'd0);

        // Pending slot refilled during the DISP cycle that launches it.
        write(32'd100, 1'b1);
        tick(4);
        write(32'h0000_00AB, 1'b0);
        tick(27);
        bus.io_we    = 1'b1;
        bus.io_wdata = 32'd7;
        bus.mode_dec = 1'b1;
        tick(1);
        bus.io_we = 1'b0;
        check_hex("coll_first", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40});
        chk("coll_busy_e33", 32'(bus.busy), 32'd1);
        tick(1);
        check_hex("coll_pending", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h03});
        chk("coll_busy_e34", 32'(bus.busy), 32'd1);
        wait_idle("coll", 60);
        check_hex("coll_seven", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78});
        chk("coll_ovf", 32'(bus.ovf), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_io_hex_display
